// File: rtl/fifo_arb_pkg.sv
// Shared types and width helpers for the FIFO write-port arbiter.
// Also usable by the read-side scheduler.
package fifo_arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        BURST = 1'b1
    } arb_state_t;

    function automatic int clog2(input int n);
        int r;
        r = 0;
        while ((1 << r) < n) r++;
        return r;
    endfunction

    // Index width never drops below one bit, even for a single requester.
    function automatic int id_width(input int n);
        return (n < 2) ? 1 : clog2(n);
    endfunction

    // One spare bit so the counter can hold MAXBURST itself.
    function automatic int cnt_width(input int m);
        return clog2(m) + 1;
    endfunction

    localparam int DATAWIDTH_DEF = 8;
    localparam int NREQ_DEF      = 4;
    localparam int MAXBURST_DEF  = 4;
    localparam int ID_W          = id_width(NREQ_DEF);
    localparam int CNT_W         = cnt_width(MAXBURST_DEF);

endpackage

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set req bit after ptr,
// wrapping modulo NREQ.
module rr_pick
    import fifo_arb_pkg::*;
#(
    parameter int NREQ = NREQ_DEF,
    parameter int IW   = ID_W
) (
    input  logic [NREQ-1:0] req,
    input  logic [IW-1:0]   ptr,
    output logic            valid,
    output logic [IW-1:0]   idx
);

    int cand;

    // Scan from farthest to nearest so the nearest hit after ptr wins.
    always_comb begin
        valid = |req;
        idx   = '0;
        cand  = 0;
        for (int k = NREQ; k >= 1; k--) begin
            cand = int'(ptr) + k;
            if (cand >= NREQ) cand = cand - NREQ;
            if (req[cand]) idx = IW'(cand);
        end
    end

endmodule

// File: rtl/fifo_wr_arbiter.sv
// Round-robin arbiter sharing the async FIFO write port between
// NREQ requesters with bounded bursts and full-flag stalls.
module fifo_wr_arbiter
    import fifo_arb_pkg::*;
#(
    parameter int Datawidth = DATAWIDTH_DEF,
    parameter int NREQ      = NREQ_DEF,
    parameter int MAXBURST  = MAXBURST_DEF
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic [NREQ-1:0]               req,
    input  logic [NREQ-1:0]               last,
    input  logic [NREQ*Datawidth-1:0]     data,
    input  logic                          full,
    output logic [NREQ-1:0]               ack,
    output logic [NREQ-1:0]               gnt,
    output logic [id_width(NREQ)-1:0]     grant_id,
    output logic                          busy,
    output logic                          w_en,
    output logic [Datawidth-1:0]          datain
);

    localparam int GID_W  = id_width(NREQ);
    localparam int BCNT_W = cnt_width(MAXBURST);
    localparam logic [BCNT_W-1:0] LAST_BEAT = BCNT_W'(MAXBURST - 1);
    localparam logic [GID_W-1:0]  PTR_RST   = GID_W'(NREQ - 1);

    arb_state_t        state_q, state_d;
    logic [NREQ-1:0]   gnt_d;
    logic [GID_W-1:0]  gid_d;
    logic              busy_d;
    logic [BCNT_W-1:0] cnt_q, cnt_d;
    logic [GID_W-1:0]  ptr_q, ptr_d;

    logic              pick_valid;
    logic [GID_W-1:0]  pick_idx;
    logic              req_g;
    logic              last_g;
    logic              accept;
    logic              burst_end;

    rr_pick #(
        .NREQ (NREQ),
        .IW   (GID_W)
    ) u_pick (
        .req   (req),
        .ptr   (ptr_q),
        .valid (pick_valid),
        .idx   (pick_idx)
    );

    assign req_g  = req[grant_id];
    assign last_g = last[grant_id];

    // Next-state and write-port decode; stall on full freezes everything.
    always_comb begin
        state_d   = state_q;
        gnt_d     = gnt;
        gid_d     = grant_id;
        busy_d    = busy;
        cnt_d     = cnt_q;
        ptr_d     = ptr_q;
        accept    = 1'b0;
        burst_end = 1'b0;
        datain    = '0;
        unique case (state_q)
            IDLE: begin
                if (pick_valid) begin
                    state_d = BURST;
                    gnt_d   = NREQ'(1) << pick_idx;
                    gid_d   = pick_idx;
                    busy_d  = 1'b1;
                    cnt_d   = '0;
                end
            end
            BURST: begin
                accept    = req_g & ~full;
                datain    = data[grant_id*Datawidth +: Datawidth];
                burst_end = (accept & (last_g | (cnt_q == LAST_BEAT)))
                          | (~req_g & ~full);
                if (accept) cnt_d = cnt_q + 1'b1;
                if (burst_end) begin
                    state_d = IDLE;
                    gnt_d   = '0;
                    busy_d  = 1'b0;
                    cnt_d   = '0;
                    ptr_d   = grant_id;
                end
            end
            default: ;
        endcase
        w_en = accept & ~rst;
        ack  = {NREQ{accept & ~rst}} & gnt;
    end

    // Grant, burst and round-robin state registers.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q  <= IDLE;
            gnt      <= '0;
            grant_id <= '0;
            busy     <= 1'b0;
            cnt_q    <= '0;
            ptr_q    <= PTR_RST;
        end else begin
            state_q  <= state_d;
            gnt      <= gnt_d;
            grant_id <= gid_d;
            busy     <= busy_d;
            cnt_q    <= cnt_d;
            ptr_q    <= ptr_d;
        end
    end

endmodule

// File: tb/tb_fifo_wr_arbiter.sv
// Self-checking bench for fifo_wr_arbiter: vector table, directed
// corner sequences and a randomized run against a reference model.
module tb_fifo_wr_arbiter;

    localparam int NR = 4;
    localparam int DW = 8;
    localparam int MB = 4;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [NR-1:0] req, last, ack, gnt;
    logic [NR*DW-1:0] data;
    logic          full, busy, w_en;
    logic [1:0]    grant_id;
    logic [DW-1:0] datain;

    logic [NR-1:0] req1, last1, ack1, gnt1;
    logic [NR*DW-1:0] data1;
    logic          full1, busy1, wen1;
    logic [1:0]    gid1;
    logic [DW-1:0] din1;

    int n_chk  = 0;
    int n_fail = 0;

    fifo_wr_arbiter #(.Datawidth(DW), .NREQ(NR), .MAXBURST(MB)) dut (
        .clk(clk), .rst(rst), .req(req), .last(last), .data(data),
        .full(full), .ack(ack), .gnt(gnt), .grant_id(grant_id),
        .busy(busy), .w_en(w_en), .datain(datain)
    );

    fifo_wr_arbiter #(.Datawidth(DW), .NREQ(NR), .MAXBURST(1)) dut1 (
        .clk(clk), .rst(rst), .req(req1), .last(last1), .data(data1),
        .full(full1), .ack(ack1), .gnt(gnt1), .grant_id(gid1),
        .busy(busy1), .w_en(wen1), .datain(din1)
    );

    always #5 clk = ~clk;

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1);
    end

    typedef struct packed {
        logic [3:0]  req;
        logic [3:0]  last;
        logic        full;
        logic [31:0] data;
        logic        wen;
        logic [3:0]  ack;
        logic [3:0]  gnt;
        logic        busy;
        logic [1:0]  gid;
        logic [7:0]  din;
    } vec_t;

    vec_t tv[$];

    function automatic vec_t mk(input logic [3:0] rq, input logic [3:0] lt,
                                input logic fl, input logic [31:0] d,
                                input logic we, input logic [3:0] ak,
                                input logic [3:0] gn, input logic bz,
                                input logic [1:0] gi, input logic [7:0] dn);
        vec_t v;
        v.req = rq; v.last = lt; v.full = fl; v.data = d;
        v.wen = we; v.ack = ak; v.gnt = gn; v.busy = bz;
        v.gid = gi; v.din = dn;
        return v;
    endfunction

    task automatic chk(input string nm, input logic [31:0] act,
                       input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h at %0t",
                     nm, act, exp, $time);
        end
    endtask

    task automatic to_neg();
        @(negedge clk);
        chk("inv_gnt_onehot0", 32'($onehot0(gnt)), 1);
        chk("inv_wen_full", 32'(w_en & full), 0);
        chk("inv_wen_ack", 32'(w_en ? $onehot(ack) : (ack == '0)), 1);
        chk("inv1_gnt_onehot0", 32'($onehot0(gnt1)), 1);
        chk("inv1_wen_full", 32'(wen1 & full1), 0);
    endtask

    task automatic to_pos();
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset();
        rst = 1'b1;
        req = '0; last = '0; data = '0; full = 1'b0;
        req1 = '0; last1 = '0; data1 = '0; full1 = 1'b0;
        @(posedge clk);
        #1;
        req = '1; req1 = '1;
        #1;
        chk("rst_gnt", 32'(gnt), 0);
        chk("rst_busy", 32'(busy), 0);
        chk("rst_gid", 32'(grant_id), 0);
        chk("rst_wen", 32'(w_en), 0);
        chk("rst_ack", 32'(ack), 0);
        chk("rst_wen1", 32'(wen1), 0);
        req = '0; req1 = '0;
        @(negedge clk);
        rst = 1'b0;
        to_pos();
    endtask

    // Reference model: grant owner (-1 when none), beats written in the
    // current grant, last finished owner, and the held grant index.
    int m_g, m_n, m_ptr, m_gid;

    task automatic m_reset();
        m_g = -1; m_n = 0; m_ptr = NR - 1; m_gid = 0;
    endtask

    task automatic m_check();
        logic acc;
        acc = (m_g >= 0) && req[m_g] && !full;
        chk("rnd_busy", 32'(busy), 32'(m_g >= 0));
        chk("rnd_gnt", 32'(gnt), (m_g >= 0) ? 32'(1 << m_g) : 0);
        chk("rnd_gid", 32'(grant_id), 32'(m_gid));
        chk("rnd_wen", 32'(w_en), 32'(acc));
        chk("rnd_ack", 32'(ack), acc ? 32'(1 << m_g) : 0);
        if (m_g >= 0) chk("rnd_din", 32'(datain), 32'(data[m_g*DW +: DW]));
    endtask

    task automatic m_step();
        logic acc;
        int   win;
        if (m_g < 0) begin
            win = -1;
            for (int k = 1; k <= NR; k++)
                if (win < 0 && req[(m_ptr + k) % NR]) win = (m_ptr + k) % NR;
            if (win >= 0) begin
                m_g = win; m_gid = win; m_n = 0;
            end
        end else begin
            acc = req[m_g] && !full;
            if (acc) m_n++;
            if ((acc && (last[m_g] || m_n == MB)) || (!req[m_g] && !full)) begin
                m_ptr = m_g;
                m_g = -1;
            end
        end
    endtask

    int n_b2;

    initial begin
        do_reset();

        // single burst of 3 from requester 1, then a stalled burst from 2
        tv.push_back(mk(4'b0010, 4'b0000, 0, 32'h0000_A100, 0, 4'b0000, 4'b0000, 0, 0, 8'h00));
        tv.push_back(mk(4'b0010, 4'b0000, 0, 32'h0000_A100, 1, 4'b0010, 4'b0010, 1, 1, 8'hA1));
        tv.push_back(mk(4'b0010, 4'b0000, 0, 32'h0000_A200, 1, 4'b0010, 4'b0010, 1, 1, 8'hA2));
        tv.push_back(mk(4'b0010, 4'b0010, 0, 32'h0000_A300, 1, 4'b0010, 4'b0010, 1, 1, 8'hA3));
        tv.push_back(mk(4'b0000, 4'b0000, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 1, 8'h00));
        tv.push_back(mk(4'b0000, 4'b0000, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 1, 8'h00));
        tv.push_back(mk(4'b0100, 4'b0000, 0, 32'h00B1_0000, 0, 4'b0000, 4'b0000, 0, 1, 8'h00));
        tv.push_back(mk(4'b0100, 4'b0000, 0, 32'h00B1_0000, 1, 4'b0100, 4'b0100, 1, 2, 8'hB1));
        for (int i = 0; i < 5; i++)
            tv.push_back(mk(4'b0100, 4'b0000, 1, 32'h00B2_0000, 0, 4'b0000, 4'b0100, 1, 2, 8'hB2));
        tv.push_back(mk(4'b0100, 4'b0000, 0, 32'h00B2_0000, 1, 4'b0100, 4'b0100, 1, 2, 8'hB2));
        tv.push_back(mk(4'b0100, 4'b0100, 0, 32'h00B3_0000, 1, 4'b0100, 4'b0100, 1, 2, 8'hB3));
        tv.push_back(mk(4'b0000, 4'b0000, 0, 32'h0000_0000, 0, 4'b0000, 4'b0000, 0, 2, 8'h00));

        n_b2 = 0;
        foreach (tv[i]) begin
            req = tv[i].req; last = tv[i].last;
            full = tv[i].full; data = tv[i].data;
            to_neg();
            chk($sformatf("tv%0d_wen", i), 32'(w_en), 32'(tv[i].wen));
            chk($sformatf("tv%0d_ack", i), 32'(ack), 32'(tv[i].ack));
            chk($sformatf("tv%0d_gnt", i), 32'(gnt), 32'(tv[i].gnt));
            chk($sformatf("tv%0d_busy", i), 32'(busy), 32'(tv[i].busy));
            chk($sformatf("tv%0d_gid", i), 32'(grant_id), 32'(tv[i].gid));
            if (tv[i].busy)
                chk($sformatf("tv%0d_din", i), 32'(datain), 32'(tv[i].din));
            if (w_en && datain == 8'hB2) n_b2++;
            to_pos();
        end
        chk("stall_b2_once", 32'(n_b2), 1);

        // all four requesting, no last: 0,1,2,3,0 with 4 beats and a gap
        do_reset();
        req = '1; data = 32'h4433_2211;
        for (int c = 0; c < 25; c++) begin
            to_neg();
            chk($sformatf("rr_wen_c%0d", c), 32'(w_en), 32'((c % 5) != 0));
            if ((c % 5) != 0) begin
                chk($sformatf("rr_gid_c%0d", c), 32'(grant_id), 32'((c / 5) % 4));
                chk($sformatf("rr_ack_c%0d", c), 32'(ack), 32'(1 << ((c / 5) % 4)));
            end
            to_pos();
        end

        // requester 3 drops after one beat; pointer must move to 3
        do_reset();
        req = 4'b0010; last = 4'b0010; data = 32'hD100_1100;
        to_neg(); chk("drop_c0_busy", 32'(busy), 0); to_pos();
        to_neg(); chk("drop_c1_gnt", 32'(gnt), 32'b0010); to_pos();
        req = 4'b1000; last = '0;
        to_neg(); chk("drop_c2_busy", 32'(busy), 0); to_pos();
        to_neg();
        chk("drop_c3_gnt", 32'(gnt), 32'b1000);
        chk("drop_c3_wen", 32'(w_en), 1);
        chk("drop_c3_din", 32'(datain), 32'hD1);
        to_pos();
        req = 4'b0110;
        to_neg();
        chk("drop_c4_wen", 32'(w_en), 0);
        chk("drop_c4_busy", 32'(busy), 1);
        to_pos();
        to_neg(); chk("drop_c5_busy", 32'(busy), 0); to_pos();
        to_neg();
        chk("drop_c6_gnt", 32'(gnt), 32'b0010);
        chk("drop_c6_gid", 32'(grant_id), 1);
        to_pos();

        // asynchronous reset in the middle of requester 1's burst
        do_reset();
        req = '1;
        for (int c = 0; c < 7; c++) begin
            to_neg(); to_pos();
        end
        to_neg();
        chk("arst_pre_gid", 32'(grant_id), 1);
        #2 rst = 1'b1;
        #1;
        chk("arst_gnt", 32'(gnt), 0);
        chk("arst_busy", 32'(busy), 0);
        chk("arst_gid", 32'(grant_id), 0);
        chk("arst_wen", 32'(w_en), 0);
        chk("arst_ack", 32'(ack), 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        to_pos();
        to_neg();
        chk("arst_after_gnt", 32'(gnt), 32'b0001);
        chk("arst_after_wen", 32'(w_en), 1);
        to_pos();

        // MAXBURST=1: strict per-beat alternation between 1 and 3
        do_reset();
        req1 = 4'b1010; data1 = 32'h3300_1100;
        for (int c = 0; c < 8; c++) begin
            to_neg();
            chk($sformatf("mb1_wen_c%0d", c), 32'(wen1), 32'(c % 2));
            if ((c % 2) == 1)
                chk($sformatf("mb1_gid_c%0d", c), 32'(gid1),
                    ((c % 4) == 1) ? 32'd1 : 32'd3);
            to_pos();
        end

        // randomized traffic against the reference model
        do_reset();
        m_reset();
        for (int c = 0; c < 600; c++) begin
            req  = 4'($urandom) | 4'($urandom);
            last = 4'($urandom) & 4'($urandom);
            full = ($urandom_range(0, 3) == 0);
            data = $urandom;
            to_neg();
            m_check();
            m_step();
            to_pos();
        end

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_arbiter.md
Name: fifo_wr_arbiter

Overview:
- Round-robin arbiter sharing the single write port of the async FIFO between NREQ requesters.
- Lives in the FIFO write-clock domain, in front of the FIFO.
- Grants one requester at a time for a bounded burst and drives the FIFO w_en/datain.
- Stalls on the FIFO full flag without losing or duplicating data.

Parameters:
Datawidth  8  width of one data beat, matches FIFO Datawidth
NREQ  4  number of requesters, 2..16
MAXBURST  4  max beats per grant, 1..16

Ports:
clk  input  1  write-side clock, same clock as the FIFO write clock
rst  input  1  reset; asynchronous and active-high
req  input  NREQ  per-requester beat valid; must hold with data until ack
last  input  NREQ  per-requester end-of-burst marker, qualified by req
data  input  NREQ*Datawidth  flattened beats, requester i at [i*Datawidth +: Datawidth]
full  input  1  FIFO full flag
ack  output  NREQ  beat of requester i accepted this cycle (combinational)
gnt  output  NREQ  registered one-hot grant
grant_id  output  clog2(NREQ)  registered index of the granted requester
busy  output  1  registered; 1 while in BURST
w_en  output  1  FIFO write enable (combinational)
datain  output  Datawidth  FIFO write data: the granted requester's beat

Behaviour:
- Reset (asynchronous, rst=1) sets: state=IDLE, gnt=0, grant_id=0, busy=0, beat_cnt=0, rr_ptr=NREQ-1 (requester 0 has first priority).
- Outputs w_en and ack are 0 while in reset.
- The FSM has two states, IDLE and BURST.
- IDLE:
  - If req != 0, select the winner g: the first set req bit scanning from rr_ptr+1 upward, modulo NREQ.
  - Next edge: gnt=onehot(g), grant_id=g, busy=1, beat_cnt=0, state=BURST.
  - w_en=0 and ack=0 in IDLE.
  - Latency from req rising to first possible write is 1 cycle.
- BURST:
  - Beat accept condition: accept = req[g] & ~full.
  - w_en=accept; ack[g]=accept; all other ack bits are 0.
  - datain = data slice g, driven whenever in BURST, independent of full.
  - On accept, beat_cnt increments.
- Burst end, evaluated each BURST cycle. Any one of these returns the FSM to IDLE next edge:
  - (a) accept & last[g];
  - (b) accept & beat_cnt==MAXBURST-1;
  - (c) ~req[g] & ~full, meaning the requester dropped.
- On burst end: gnt=0, busy=0, rr_ptr=g.
- This leaves a mandatory 1-cycle IDLE gap between bursts.
- full=1 in BURST:
  - Stall: w_en=0, ack=0, beat_cnt holds, grant holds.
  - Condition (c) is not evaluated while full.
  - The stall can be unbounded.
- Other requesters' req/last/data are ignored while not granted.
- MAXBURST=1 gives one beat per grant, i.e. strict per-beat round-robin.
- rr_ptr wraps from NREQ-1 to 0.
- beat_cnt width is clog2(MAXBURST)+1, with no overflow (bounded by end condition (b)).
- Reset asserted mid-burst: an immediate return to reset values.
  - The in-flight beat is not written unless accept was already sampled on a prior edge.
  - No partial state survives reset.
- Invariants:
  - gnt is zero or one-hot.
  - w_en implies exactly one ack bit set.
  - w_en is never 1 when full=1.

Decomposition:
- Package fifo_arb_pkg holds:
  - the state enum {IDLE, BURST};
  - a clog2 constant function;
  - the local width constants (ID_W, CNT_W).
- One sub-module, rr_pick: combinational round-robin picker.
  - Inputs: req[NREQ], ptr.
  - Outputs: valid, idx.
  - Reusable by the read-side scheduler.

Test Plan:
- Single requester, burst of 3 with last on beat 3:
  - req[1]=1 at cycle 0 → gnt=4'b0010 at cycle 1.
  - w_en high on cycles 1, 2, 3, datain = beats 1..3 in order.
  - busy=0 at cycle 4.
- All 4 requesting continuously, MAXBURST=4, last never set:
  - grant order is 0,1,2,3,0.
  - Each grant gives exactly 4 writes, with a 1-cycle gap between grants.
- full asserted for 5 cycles mid-burst, on beat 2 of requester 2:
  - w_en=0 and ack=0 for those 5 cycles; beat_cnt holds.
  - Beat 2 is written exactly once after full drops; no data loss or duplication.
- Requester 3 drops req after beat 1 with full=0:
  - back to IDLE next cycle, rr_ptr=3.
  - The next winner is the lowest set req starting from 0.
- rst pulsed high mid-burst (async, between edges):
  - gnt, busy and grant_id go to 0 immediately; w_en goes to 0.
  - After release, requester 0 wins first when all request.
- MAXBURST=1, req=4'b1010 held:
  - alternating single-beat grants 1,3,1,3.
  - Assertion checks: gnt one-hot or zero, and w_en never high while full is high.
